// File: rtl/arb_pkg.sv
// arb_pkg: shared sizes and FSM state encoding for the 4-way round-robin arbiter
package arb_pkg;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority encoder, first set req bit at or above ptr with wrap
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             valid
);
    logic [SEL_W-1:0] j;
    // scan from the farthest offset down so the nearest set bit to ptr wins
    always_comb begin
        idx = '0;
        j   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = ptr + SEL_W'(i);
            if (req[j]) idx = j;
        end
    end
    assign valid = |req;
endmodule

// File: rtl/rr_arb4.sv
// rr_arb4: 4-source round-robin grant FSM; ARB_TIMEOUT_EN adds a forced release after HOLD_MAX cycles
module rr_arb4
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic             timeout
);
    state_t           state, nxt_state;
    logic [SEL_W-1:0] ptr, nxt_ptr, nxt_sel, pick_idx;
    logic             pick_valid, rel, expire, nxt_to;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign rel  = done | ~req[sel];
    assign busy = (state == GRANT);
    assign gnt  = busy ? (N_REQ'(1) << sel) : '0;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    logic [CNT_W-1:0] cnt;
    assign expire = (cnt == CNT_W'(HOLD_MAX - 1)) & ~rel;
    // hold counter: zero outside GRANT so it starts fresh on each grant entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= busy ? cnt + 1'b1 : '0;
    end
    // timeout pulses for the one cycle following a forced release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timeout <= 1'b0;
        else        timeout <= nxt_to;
    end
`else
    logic unused_hold;
    assign unused_hold = (HOLD_MAX > 0);
    assign expire      = 1'b0;
    assign timeout     = 1'b0;
`endif

    // next-state: grant the picked source from IDLE, release on done/req drop/expiry
    always_comb begin
        nxt_state = state;
        nxt_sel   = sel;
        nxt_ptr   = ptr;
        nxt_to    = 1'b0;
        if (state == IDLE) begin
            if (pick_valid) begin
                nxt_state = GRANT;
                nxt_sel   = pick_idx;
            end
        end else if (rel | expire) begin
            nxt_state = IDLE;
            nxt_ptr   = sel + 1'b1;
            nxt_to    = expire;
        end
    end

    // state, select and round-robin pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= '0;
            ptr   <= '0;
        end else begin
            state <= nxt_state;
            sel   <= nxt_sel;
            ptr   <= nxt_ptr;
        end
    end
endmodule

// File: tb/tb_rr_arb4.sv
// tb_rr_arb4: directed self-checking bench for rr_arb4
module tb_rr_arb4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0;
    logic       done = 1'b0;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       busy;
    logic       timeout;
    int         tests = 0;
    int         fails = 0;
    int         n;
    int         bad;
    logic [1:0] exp_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rr_arb4 #(.HOLD_MAX(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [1:0] s);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
        chk({tag, "_sel"}, {6'd0, sel}, {6'd0, s});
        chk({tag, "_gnt"}, {4'd0, gnt}, {4'd0, 4'b0001 << s});
    endtask

    initial begin
        #2;
        chk("rst_sel", {6'd0, sel}, 8'd0);
        chk("rst_gnt", {4'd0, gnt}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_to", {7'd0, timeout}, 8'd0);
        #10 rst_n = 1'b1;
        tick;
        done = 1'b1;
        tick;
        chk("idle_done_gnt", {4'd0, gnt}, 8'd0);
        chk("idle_done_busy", {7'd0, busy}, 8'd0);
        chk("idle_done_sel", {6'd0, sel}, 8'd0);
        done = 1'b0;
        req = 4'b0100;
        tick;
        chk_grant("g2", 2'd2);
        done = 1'b1;
        tick;
        chk("rel2_gnt", {4'd0, gnt}, 8'd0);
        chk("rel2_busy", {7'd0, busy}, 8'd0);
        chk("rel2_sel_hold", {6'd0, sel}, 8'd2);
        done = 1'b0;
        req = 4'b1111;
        tick;
        chk_grant("ptr3", 2'd3);
        for (int k = 0; k < 5; k++) begin
            done = 1'b1;
            tick;
            chk("rr_idle_gnt", {4'd0, gnt}, 8'd0);
            done = 1'b0;
            tick;
            chk_grant("rr", exp_seq[k]);
        end
        req = 4'b0010;
        done = 1'b1;
        tick;
        done = 1'b0;
        tick;
        chk_grant("g1", 2'd1);
        req = 4'b1011;
        tick;
        chk_grant("g1_other", 2'd1);
        tick;
        chk_grant("g1_other2", 2'd1);
        req = 4'b1001;
        tick;
        chk("drop_busy", {7'd0, busy}, 8'd0);
        chk("drop_gnt", {4'd0, gnt}, 8'd0);
        tick;
        chk_grant("after_drop", 2'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_gnt", {4'd0, gnt}, 8'd0);
        chk("async_busy", {7'd0, busy}, 8'd0);
        req = 4'b1010;
        #2 rst_n = 1'b1;
        tick;
        chk_grant("post_rst", 2'd1);
        done = 1'b1;
        tick;
        done = 1'b0;
        req = 4'b0100;
        tick;
        chk_grant("hold_g2", 2'd2);
`ifdef ARB_TIMEOUT_EN
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick;
        end
        chk("hold_len", 8'(n), 8'd16);
        chk("to_pulse", {7'd0, timeout}, 8'd1);
        tick;
        chk("to_clear", {7'd0, timeout}, 8'd0);
        chk_grant("regrant", 2'd2);
`else
        bad = 0;
        for (int k = 0; k < 120; k++) begin
            tick;
            if (busy !== 1'b1 || timeout !== 1'b0 || sel !== 2'd2) bad++;
        end
        chk("unbounded_hold", 8'(bad), 8'd0);
`endif
        req = 4'b0000;
        done = 1'b1;
        tick;
        chk("dual_rel_busy", {7'd0, busy}, 8'd0);
        done = 1'b0;
        req = 4'b1111;
        tick;
        chk_grant("dual_rel_next", 2'd3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
